siso_frame_ctrl: RTL and testbench

Sequencer wrapped around the serial shift-register datapath. It accepts parallel words over a valid/ready handshake and serializes each word LSB-first on `sdo` with a `frame` strobe. In the same bit cycles it captures `sdi`, full-duplex, and returns the received word in parallel. It is the control layer between parallel logic and the single-bit serial path.

---
 rtl/siso_frame_ctrl_pkg.sv | 18 +
 rtl/siso_shift_core.sv | 34 +++
 rtl/siso_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_siso_frame_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_frame_ctrl_pkg.sv
// Shared types and helpers for the siso_frame_ctrl serial sequencer.
package siso_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Counter wide enough to hold values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/siso_shift_core.sv
// Full-duplex shift datapath: LSB-first transmit register and MSB-in receive register.
module siso_shift_core
  import siso_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  input  logic             sdi,
  output logic             sdo,
  output logic [WIDTH-1:0] rx_word
);

  logic [WIDTH-1:0] tx_reg;

  // Zeros fill the TX register behind the data, so sdo idles low once a frame is out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_reg  <= '0;
      rx_word <= '0;
    end else if (load) begin
      tx_reg <= din;
    end else if (shift_en) begin
      tx_reg  <= {1'b0, tx_reg[WIDTH-1:1]};
      rx_word <= {sdi, rx_word[WIDTH-1:1]};
    end
  end

  assign sdo = tx_reg[0];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Parallel-to-serial frame sequencer with full-duplex receive.
// Optional even-parity bit enabled by defining SISO_FRAME_CTRL_PARITY_EN.
module siso_frame_ctrl
  import siso_frame_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             frame,
  output logic             busy,
  input  logic             sdi,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             done
`ifdef SISO_FRAME_CTRL_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SISO_FRAME_CTRL_PARITY_EN
  localparam int CORE_W = WIDTH + 1;
`else
  localparam int CORE_W = WIDTH;
`endif
  localparam int CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              load, shift_en, frame_end, done_pend;
  logic [CORE_W-1:0] core_din, rx_word;

  // The parity bit rides in the TX register just above the data bits
`ifdef SISO_FRAME_CTRL_PARITY_EN
  assign core_din = {^din, din};
`else
  assign core_din = din;
`endif

  siso_shift_core #(
    .WIDTH(CORE_W)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift_en (shift_en),
    .din      (core_din),
    .sdi      (sdi),
    .sdo      (sdo),
    .rx_word  (rx_word)
  );

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    load       = 1'b0;
    shift_en   = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          load       = 1'b1;
          cnt_next   = '0;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          cnt_next = '0;
`ifdef SISO_FRAME_CTRL_PARITY_EN
          next_state = PARITY;
`else
          next_state = AFTER_FRAME;
          frame_end  = 1'b1;
`endif
        end
      end
`ifdef SISO_FRAME_CTRL_PARITY_EN
      PARITY: begin
        shift_en   = 1'b1;
        frame_end  = 1'b1;
        next_state = AFTER_FRAME;
      end
`endif
      GAP: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_GAP) begin
          cnt_next   = '0;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame      <= 1'b0;
      busy       <= 1'b0;
      din_ready  <= 1'b0;
      done_pend  <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
`ifdef SISO_FRAME_CTRL_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      frame      <= (next_state == SHIFT) || (next_state == PARITY);
      busy       <= (next_state != IDLE);
      din_ready  <= (next_state == IDLE);
      done_pend  <= frame_end;
      done       <= done_pend;
      dout_valid <= done_pend;
      if (done_pend) begin
        dout <= rx_word[WIDTH-1:0];
`ifdef SISO_FRAME_CTRL_PARITY_EN
        parity_err <= ^rx_word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Scoreboard bench for siso_frame_ctrl: directed cases plus randomized words and sdi patterns.
module tb_siso_frame_ctrl;

  localparam int W   = 8;
  localparam int GAP = 2;
`ifdef SISO_FRAME_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = W + PAR;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, sdo, frame, busy, dout_valid, done;
  logic         sdi = 1'b0;
  logic [W-1:0] dout;
`ifdef SISO_FRAME_CTRL_PARITY_EN
  logic         parity_err;
`endif

  // Expected words: tx_q holds transmitted data, rx_q/sdi_q hold {bad_parity, rx_word}
  logic [W-1:0] tx_q[$];
  logic [W:0]   rx_q[$];
  logic [W:0]   sdi_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_start = 0;
  int prev_start = 0;

  siso_frame_ctrl #(
    .WIDTH(W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sdo        (sdo),
    .frame      (frame),
    .busy       (busy),
    .sdi        (sdi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
`ifdef SISO_FRAME_CTRL_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic [W:0] plan, input bit hold);
    int budget;
    budget = 100;
    din = w;
    din_valid = 1'b1;
    while (!din_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!din_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL handshake_timeout: din_ready=%0b, expected 1", din_ready);
      din_valid = 1'b0;
    end else begin
      tx_q.push_back(w);
      rx_q.push_back(plan);
      sdi_q.push_back(plan);
      @(negedge clk);
      if (!hold) din_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 300;
    while ((rx_q.size() != 0 || tx_q.size() != 0 || busy) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_rx_q", rx_q.size(), 0);
  endtask

  // sdi driver: plays each frame's planned receive bits, random noise between frames
  initial begin
    logic [W:0] plan;
    int bit_idx;
    bit active;
    active = 1'b0;
    bit_idx = 0;
    plan = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        sdi = 1'b0;
      end else if (frame) begin
        if (!active) begin
          plan = (sdi_q.size() > 0) ? sdi_q.pop_front() : '0;
          active = 1'b1;
          bit_idx = 0;
        end
        if (bit_idx < W) sdi = plan[bit_idx];
        else sdi = (^plan[W-1:0]) ^ plan[W];
        bit_idx++;
      end else begin
        active = 1'b0;
        sdi = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // Monitor: compares serial bits, frame length, handshake gap and received words
  initial begin
    logic [W-1:0] cur_tx;
    logic [W:0]   exp_rx;
    logic         exp_bit;
    int           bitn;
    bit           in_frame, wait_ready;
    in_frame = 1'b0;
    wait_ready = 1'b0;
    bitn = 0;
    cur_tx = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_ctrl_outputs", {26'd0, sdo, frame, busy, done, dout_valid, din_ready}, 0);
        check("reset_dout", dout, 0);
`ifdef SISO_FRAME_CTRL_PARITY_EN
        check("reset_parity_err", parity_err, 0);
`endif
        in_frame = 1'b0;
        wait_ready = 1'b0;
      end else begin
        if (frame) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            bitn = 0;
            prev_start = last_start;
            last_start = cyc;
            if (tx_q.size() == 0) begin
              checks++;
              fails++;
              $display("[TB] FAIL unexpected_frame: frame=1, expected 0 (cycle %0d)", cyc);
              cur_tx = '0;
            end else begin
              cur_tx = tx_q.pop_front();
            end
          end
          if (bitn < W) exp_bit = cur_tx[bitn];
          else exp_bit = ^cur_tx;
          check("sdo_bit", sdo, exp_bit);
          check("ready_low_in_frame", din_ready, 0);
          bitn++;
        end else begin
          check("sdo_idle_low", sdo, 0);
          if (in_frame) begin
            in_frame = 1'b0;
            check("frame_length", bitn, FLEN);
            fall_cyc = cyc;
            wait_ready = 1'b1;
          end
        end
        if (wait_ready && din_ready) begin
          wait_ready = 1'b0;
          check("ready_gap", cyc - fall_cyc, GAP);
        end
        if (done || dout_valid) begin
          check("done_with_dout_valid", {30'd0, done, dout_valid}, 3);
          check("done_latency", cyc - fall_cyc, 1);
          if (rx_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_done: dout_valid=%0b, expected 0 (cycle %0d)", dout_valid, cyc);
          end else begin
            exp_rx = rx_q.pop_front();
            check("dout", dout, exp_rx[W-1:0]);
`ifdef SISO_FRAME_CTRL_PARITY_EN
            check("parity_err", parity_err, exp_rx[W]);
`endif
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [W:0]   plan;
    bit           hold;

    // Reset with a word offered: nothing may leave the block
    din = 8'h5A;
    din_valid = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", din_ready, 1);
    din_valid = 1'b0;
    @(negedge clk);

    send_word(8'hA5, {1'b0, 8'hA5}, 1'b0);
    send_word(8'h00, {1'b0, 8'hFF}, 1'b0);
    wait_drain();

    // Back-to-back with valid held: period is frame + gap + handshake
    send_word(8'h01, {1'b0, 8'h01}, 1'b1);
    send_word(8'h80, {1'b0, 8'h80}, 1'b0);
    wait_drain();
    check("b2b_period", last_start - prev_start, FLEN + GAP + 1);

    // Abort during bit 4, then a clean loopback frame
    send_word(8'hFF, {1'b0, 8'hFF}, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    tx_q.delete();
    rx_q.delete();
    sdi_q.delete();
    #1;
    check("abort_frame", frame, 0);
    check("abort_sdo", sdo, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_word(8'h3C, {1'b0, 8'h3C}, 1'b0);
    wait_drain();

`ifdef SISO_FRAME_CTRL_PARITY_EN
    send_word(8'h07, {1'b0, 8'h07}, 1'b0);
    send_word(8'h07, {1'b1, 8'h07}, 1'b0);
    wait_drain();
`endif

    for (int i = 0; i < 24; i++) begin
      w = W'($urandom);
      if ($urandom_range(0, 2) == 0) plan[W-1:0] = w;
      else plan[W-1:0] = W'($urandom);
      plan[W] = (PAR == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      hold = (i != 23) && ($urandom_range(0, 3) == 0);
      send_word(w, plan, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
